// File: rtl/gmii_rx_framer_pkg.sv
// Shared definitions for the GMII receive framer: FIFO word layout,
// preamble/SFD bytes, CRC-32 constants and the framer state encoding.
// Optional feature macro: GMII_RX_CRC_EN (FCS checking).
package gmii_rx_framer_pkg;

  // FIFO word layout
  localparam int FIFO_W      = 18;
  localparam int ST_BIT      = 17;  // word is a status word
  localparam int FIRST_BIT   = 16;  // first data word of a frame
  localparam int CRC_ERR_BIT = 15;
  localparam int TRUNC_BIT   = 14;
  localparam int LONG_BIT    = 13;
  localparam int RUNT_BIT    = 12;
  localparam int LEN_MSB     = 10;
  localparam int LEN_W       = LEN_MSB + 1;

  localparam logic [LEN_W-1:0] LEN_SAT = '1;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  // Reflected form of polynomial 0x04C11DB7
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_DATA,
    ST_FLUSH,
    ST_STATUS,
    ST_DROP
  } state_e;

  // Low 16 bits of a status word; bit 11 stays zero.
  function automatic logic [15:0] status_bits(input logic             crc_err,
                                              input logic             trunc,
                                              input logic             too_long,
                                              input logic             runt,
                                              input logic [LEN_W-1:0] len);
    logic [15:0] s;
    s              = '0;
    s[CRC_ERR_BIT] = crc_err;
    s[TRUNC_BIT]   = trunc;
    s[LONG_BIT]    = too_long;
    s[RUNT_BIT]    = runt;
    s[LEN_MSB:0]   = len;
    return s;
  endfunction

endpackage

// File: rtl/gmii_rx_framer_crc32.sv
// crc32_byte: one-byte step of the reflected Ethernet CRC-32.
// Only instantiated when GMII_RX_CRC_EN is defined.
module crc32_byte
  import gmii_rx_framer_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  // Eight LSB-first shift/xor steps of the reflected polynomial
  always_comb begin
    crc_out = crc_in ^ {24'h0, data};
    for (int i = 0; i < 8; i++)
      crc_out = crc_out[0] ? ((crc_out >> 1) ^ CRC_POLY_REFL) : (crc_out >> 1);
  end

endmodule

// File: rtl/gmii_rx_framer.sv
// gmii_rx_framer: strips preamble/SFD from GMII receive data, packs bytes
// into 16-bit network-order words and appends one status word per frame.
// The PHY cannot be stalled: FIFO full truncates a frame's data, or drops a
// whole frame when the previous frame's status is still waiting.
// Optional feature macro: GMII_RX_CRC_EN (FCS check; crc_err is 0 without it).
module gmii_rx_framer
  import gmii_rx_framer_pkg::*;
#(
  parameter int MAX_LEN = 1522,
  parameter int MIN_LEN = 64
) (
  input  logic        gmii_rx_clk,
  input  logic        sys_rst,
  input  logic [7:0]  gmii_rxd,
  input  logic        gmii_rx_dv,
  input  logic        rx_fifo_full,
  output logic        rx_fifo_we,
  output logic [17:0] rx_fifo_din,
  output logic [15:0] rx_frame_cnt,
  output logic [15:0] rx_drop_cnt
);

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] MIN_LEN_L = LEN_W'(MIN_LEN);

  logic [7:0]       rxd_q;
  logic             dv_q;
  state_e           state_q, state_d;
  logic [7:0]       hi_q, hi_d;
  logic             odd_q, odd_d;
  logic             first_q, first_d;
  logic             trunc_q, trunc_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             dslot_vld_q, dslot_vld_d;   // data word presented to FIFO
  logic             dfirst_q, dfirst_d;
  logic [15:0]      dword_q, dword_d;
  logic             spend_q, spend_d;           // status word presented/held
  logic [15:0]      sword_q, sword_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic [15:0]      drop_cnt_q, drop_cnt_d;

  logic             dwr, swr, trunc_now, pair_ok, crc_err;
  logic [LEN_W-1:0] len_inc;
  logic [15:0]      sword_nxt;

`ifdef GMII_RX_CRC_EN
  logic [31:0] crc_q, crc_d, crc_nxt;

  crc32_byte u_crc (
    .crc_in  (crc_q),
    .data    (rxd_q),
    .crc_out (crc_nxt)
  );

  assign crc_err = (crc_q != CRC_RESIDUE);
`else
  assign crc_err = 1'b0;
`endif

  // Register the PHY pins once; everything downstream uses this copy
  always_ff @(posedge gmii_rx_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rxd_q <= '0;
      dv_q  <= 1'b0;
    end else begin
      rxd_q <= gmii_rxd;
      dv_q  <= gmii_rx_dv;
    end
  end

  // FIFO port: a data word wins over a status word; full gates the strobe,
  // and a data word seen with full is lost (which truncates the frame)
  always_comb begin
    dwr         = dslot_vld_q & ~rx_fifo_full;
    swr         = ~dslot_vld_q & spend_q & ~rx_fifo_full;
    rx_fifo_we  = dwr | swr;
    rx_fifo_din = '0;
    if (dslot_vld_q) begin
      rx_fifo_din[FIRST_BIT] = dfirst_q;
      rx_fifo_din[15:0]      = dword_q;
    end else if (spend_q) begin
      rx_fifo_din[ST_BIT]    = 1'b1;
      rx_fifo_din[15:0]      = sword_q;
    end
  end

  // Next-state logic for framing, length, CRC, status and counters
  always_comb begin
    trunc_now = trunc_q | (dslot_vld_q & rx_fifo_full);
    len_inc   = (len_q == LEN_SAT) ? len_q : len_q + 1'b1;
    // len_q is the 1-based index of the pair's first (or the flushed) byte
    pair_ok   = (len_q <= MAX_LEN_L) & ~trunc_now;
    sword_nxt = status_bits(crc_err, trunc_now, len_q > MAX_LEN_L,
                            len_q < MIN_LEN_L, len_q);

    state_d     = state_q;
    hi_d        = hi_q;
    odd_d       = odd_q;
    first_d     = first_q;
    trunc_d     = trunc_now;
    len_d       = len_q;
    dslot_vld_d = 1'b0;
    dfirst_d    = dfirst_q;
    dword_d     = dword_q;
    spend_d     = spend_q & ~swr;
    sword_d     = sword_q;
    frame_cnt_d = (swr && frame_cnt_q != 16'hFFFF) ? frame_cnt_q + 16'd1 : frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
`ifdef GMII_RX_CRC_EN
    crc_d       = crc_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (dv_q) state_d = (rxd_q == PREAMBLE_BYTE) ? ST_PREAMBLE : ST_DROP;
      end
      ST_PREAMBLE: begin
        if (!dv_q) begin
          state_d = ST_IDLE;
        end else if (rxd_q == SFD_BYTE) begin
          state_d = ST_DATA;
          len_d   = '0;
          odd_d   = 1'b0;
          first_d = 1'b1;
          trunc_d = 1'b0;
`ifdef GMII_RX_CRC_EN
          crc_d   = CRC_INIT;
`endif
        end else if (rxd_q != PREAMBLE_BYTE) begin
          state_d = ST_DROP;
        end
      end
      ST_DATA: begin
        if (dv_q) begin
          len_d = len_inc;
`ifdef GMII_RX_CRC_EN
          crc_d = crc_nxt;
`endif
          if (!odd_q) begin
            hi_d  = rxd_q;
            odd_d = 1'b1;
          end else begin
            odd_d = 1'b0;
            if (pair_ok) begin
              dslot_vld_d = 1'b1;
              dfirst_d    = first_q;
              dword_d     = {hi_q, rxd_q};
              first_d     = 1'b0;
            end
          end
        end else if (odd_q) begin
          // Odd frame: emit the dangling byte now; status goes next cycle
          odd_d   = 1'b0;
          state_d = ST_FLUSH;
          if (pair_ok) begin
            dslot_vld_d = 1'b1;
            dfirst_d    = first_q;
            dword_d     = {hi_q, 8'h00};
            first_d     = 1'b0;
          end
        end else begin
          spend_d = 1'b1;
          sword_d = sword_nxt;
          state_d = ST_STATUS;
        end
      end
      ST_FLUSH: begin
        spend_d = 1'b1;
        sword_d = sword_nxt;
        state_d = ST_STATUS;
      end
      ST_STATUS: begin
        if (swr) begin
          state_d = ST_IDLE;
        end else if (dv_q) begin
          // New frame while status is still held: discard it whole
          state_d = ST_DROP;
          if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
        end
      end
      ST_DROP: begin
        if (!dv_q) state_d = (spend_q && !swr) ? ST_STATUS : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Framer state registers
  always_ff @(posedge gmii_rx_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= ST_IDLE;
      hi_q        <= '0;
      odd_q       <= 1'b0;
      first_q     <= 1'b0;
      trunc_q     <= 1'b0;
      len_q       <= '0;
      dslot_vld_q <= 1'b0;
      dfirst_q    <= 1'b0;
      dword_q     <= '0;
      spend_q     <= 1'b0;
      sword_q     <= '0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      hi_q        <= hi_d;
      odd_q       <= odd_d;
      first_q     <= first_d;
      trunc_q     <= trunc_d;
      len_q       <= len_d;
      dslot_vld_q <= dslot_vld_d;
      dfirst_q    <= dfirst_d;
      dword_q     <= dword_d;
      spend_q     <= spend_d;
      sword_q     <= sword_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

`ifdef GMII_RX_CRC_EN
  // Running FCS register
  always_ff @(posedge gmii_rx_clk or posedge sys_rst) begin
    if (sys_rst) crc_q <= CRC_INIT;
    else         crc_q <= crc_d;
  end
`endif

  assign rx_frame_cnt = frame_cnt_q;
  assign rx_drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_gmii_rx_framer.sv
// Directed bench for gmii_rx_framer: builds frames with a proper FCS, drives
// them with preamble/SFD and compares captured FIFO words with expectations.
module tb_gmii_rx_framer;

  logic        gmii_rx_clk = 1'b0;
  logic        sys_rst     = 1'b1;
  logic [7:0]  gmii_rxd    = '0;
  logic        gmii_rx_dv  = 1'b0;
  logic        rx_fifo_full = 1'b0;
  logic        rx_fifo_we;
  logic [17:0] rx_fifo_din;
  logic [15:0] rx_frame_cnt, rx_drop_cnt;

  int n_vec = 0;
  int n_err = 0;
  int we_full_viol = 0;
  int exp_frames = 0;
  int exp_drops  = 0;

  logic [17:0] cap[$];
  logic [17:0] exp_q[$];
  logic [7:0]  frm[$];

  always #4 gmii_rx_clk = ~gmii_rx_clk;

  gmii_rx_framer dut (
    .gmii_rx_clk  (gmii_rx_clk),
    .sys_rst      (sys_rst),
    .gmii_rxd     (gmii_rxd),
    .gmii_rx_dv   (gmii_rx_dv),
    .rx_fifo_full (rx_fifo_full),
    .rx_fifo_we   (rx_fifo_we),
    .rx_fifo_din  (rx_fifo_din),
    .rx_frame_cnt (rx_frame_cnt),
    .rx_drop_cnt  (rx_drop_cnt)
  );

  // FIFO model: capture every written word
  always @(negedge gmii_rx_clk) begin
    if (rx_fifo_we) cap.push_back(rx_fifo_din);
    if (rx_fifo_we && rx_fifo_full) we_full_viol++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge gmii_rx_clk);
    #1;
  endtask

  // Bitwise reference CRC-32 (reflected), feedback form
  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[0] ^ b[i];
      r  = r >> 1;
      if (fb) r = r ^ 32'hEDB88320;
    end
    return r;
  endfunction

  // n bytes total: n-4 payload bytes plus FCS (LSB first)
  task automatic build_frame(input int n, input bit corrupt, input int seed);
    logic [31:0] c;
    logic [7:0]  b;
    frm.delete();
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n - 4; i++) begin
      b = 8'(seed + i * 7);
      frm.push_back(b);
      c = crc_upd(c, b);
    end
    c = ~c;
    for (int k = 0; k < 4; k++) frm.push_back(c[8*k +: 8]);
    if (corrupt) frm[n-1] = frm[n-1] ^ 8'h01;
  endtask

  // Expected FIFO content: up to max_words data words, then the status
  task automatic make_exp(input logic [17:0] st, input int max_words);
    logic [7:0] lo;
    exp_q.delete();
    for (int i = 0; i < frm.size() && i / 2 < max_words; i += 2) begin
      lo = (i + 1 < frm.size()) ? frm[i+1] : 8'h00;
      exp_q.push_back({1'b0, (i == 0), frm[i], lo});
    end
    exp_q.push_back(st);
  endtask

  // Preamble + SFD + frame; full raised at byte index full_on (and released
  // at dv fall), or released at byte index full_off
  task automatic send_frame(input int full_on, input int full_off, input int ifg);
    for (int i = 0; i < 7; i++) begin
      gmii_rx_dv = 1'b1; gmii_rxd = 8'h55; tick();
    end
    gmii_rxd = 8'hD5; tick();
    for (int i = 0; i < frm.size(); i++) begin
      if (i == full_on)  rx_fifo_full = 1'b1;
      if (i == full_off) rx_fifo_full = 1'b0;
      gmii_rxd = frm[i];
      tick();
    end
    gmii_rx_dv = 1'b0;
    gmii_rxd   = 8'h00;
    if (full_on >= 0) rx_fifo_full = 1'b0;
    repeat (ifg) tick();
  endtask

  task automatic test_reset();
    n_vec++;
    if (rx_fifo_we !== 1'b0 || rx_fifo_din !== 18'h0) begin
      n_err++;
      $display("FAIL reset outputs: we=%b din=%h, want we=0 din=0", rx_fifo_we, rx_fifo_din);
    end
    n_vec++;
    if (rx_frame_cnt !== 16'd0 || rx_drop_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL reset counters: frame=%0d drop=%0d, want 0 0", rx_frame_cnt, rx_drop_cnt);
    end
    sys_rst = 1'b0;
    repeat (4) tick();
    n_vec++;
    if (cap.size() != 0) begin
      n_err++;
      $display("FAIL reset idle writes: got %0d want 0", cap.size());
    end
  endtask

  task automatic test_good64();
    cap.delete();
    build_frame(64, 1'b0, 3);
    make_exp(18'h20040, 1000);
    send_frame(-1, -1, 12);
    exp_frames++;
    n_vec++;
    if (cap.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL good64 word count: got %0d want %0d", cap.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
      n_vec++;
      if (cap[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL good64 word %0d: got %h want %h", i, cap[i], exp_q[i]);
      end
    end
    n_vec++;
    if (rx_frame_cnt !== 16'(exp_frames)) begin
      n_err++;
      $display("FAIL good64 frame_cnt: got %0d want %0d", rx_frame_cnt, exp_frames);
    end
  endtask

  task automatic test_bad65();
    logic [17:0] st;
`ifdef GMII_RX_CRC_EN
    st = 18'h28041;
`else
    st = 18'h20041;
`endif
    cap.delete();
    build_frame(65, 1'b1, 11);
    make_exp(st, 1000);
    send_frame(-1, -1, 12);
    exp_frames++;
    n_vec++;
    if (cap.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL bad65 word count: got %0d want %0d", cap.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
      n_vec++;
      if (cap[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL bad65 word %0d: got %h want %h", i, cap[i], exp_q[i]);
      end
    end
    n_vec++;
    if (rx_frame_cnt !== 16'(exp_frames)) begin
      n_err++;
      $display("FAIL bad65 frame_cnt: got %0d want %0d", rx_frame_cnt, exp_frames);
    end
  endtask

  task automatic test_truncate();
    cap.delete();
    we_full_viol = 0;
    build_frame(100, 1'b0, 40);
    make_exp(18'h24064, 9);
    send_frame(20, -1, 12);
    exp_frames++;
    n_vec++;
    if (cap.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL trunc word count: got %0d want %0d", cap.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
      n_vec++;
      if (cap[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL trunc word %0d: got %h want %h", i, cap[i], exp_q[i]);
      end
    end
    n_vec++;
    if (we_full_viol != 0) begin
      n_err++;
      $display("FAIL trunc we while full: got %0d want 0", we_full_viol);
    end
  endtask

  task automatic test_held_status();
    cap.delete();
    we_full_viol = 0;
    build_frame(64, 1'b0, 77);
    make_exp(18'h20040, 1000);
    send_frame(-1, -1, 2);
    rx_fifo_full = 1'b1;           // status is waiting from this cycle on
    repeat (10) tick();
    n_vec++;
    if (cap.size() != exp_q.size() - 1) begin
      n_err++;
      $display("FAIL held status early: got %0d words want %0d", cap.size(), exp_q.size() - 1);
    end
    build_frame(80, 1'b0, 5);
    send_frame(-1, 10, 12);
    exp_frames++;
    exp_drops++;
    n_vec++;
    if (cap.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL held word count: got %0d want %0d", cap.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
      n_vec++;
      if (cap[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL held word %0d: got %h want %h", i, cap[i], exp_q[i]);
      end
    end
    n_vec++;
    if (rx_drop_cnt !== 16'(exp_drops) || rx_frame_cnt !== 16'(exp_frames)) begin
      n_err++;
      $display("FAIL held counters: drop=%0d frame=%0d want %0d %0d",
               rx_drop_cnt, rx_frame_cnt, exp_drops, exp_frames);
    end
    n_vec++;
    if (we_full_viol != 0) begin
      n_err++;
      $display("FAIL held we while full: got %0d want 0", we_full_viol);
    end
  endtask

  task automatic test_bad_preamble();
    cap.delete();
    gmii_rx_dv = 1'b1;
    gmii_rxd = 8'h55; tick();
    gmii_rxd = 8'h55; tick();
    gmii_rxd = 8'h5D; tick();
    for (int i = 0; i < 20; i++) begin
      gmii_rxd = 8'(8'hD5 + i); tick();
    end
    gmii_rx_dv = 1'b0;
    repeat (12) tick();
    n_vec++;
    if (cap.size() != 0) begin
      n_err++;
      $display("FAIL bad preamble writes: got %0d want 0", cap.size());
    end
    n_vec++;
    if (rx_frame_cnt !== 16'(exp_frames) || rx_drop_cnt !== 16'(exp_drops)) begin
      n_err++;
      $display("FAIL bad preamble counters: frame=%0d drop=%0d want %0d %0d",
               rx_frame_cnt, rx_drop_cnt, exp_frames, exp_drops);
    end
    build_frame(64, 1'b0, 9);
    make_exp(18'h20040, 1000);
    send_frame(-1, -1, 12);
    exp_frames++;
    n_vec++;
    if (cap.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL after bad preamble word count: got %0d want %0d", cap.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
      n_vec++;
      if (cap[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL after bad preamble word %0d: got %h want %h", i, cap[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    build_frame(64, 1'b0, 21);
    for (int i = 0; i < 7; i++) begin
      gmii_rx_dv = 1'b1; gmii_rxd = 8'h55; tick();
    end
    gmii_rxd = 8'hD5; tick();
    for (int i = 0; i < 30; i++) begin
      gmii_rxd = frm[i]; tick();
    end
    sys_rst = 1'b1;
    gmii_rx_dv = 1'b0;
    gmii_rxd = 8'h00;
    tick(); tick();
    n_vec++;
    if (rx_fifo_we !== 1'b0 || rx_fifo_din !== 18'h0 ||
        rx_frame_cnt !== 16'd0 || rx_drop_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL mid reset: we=%b din=%h frame=%0d drop=%0d want all 0",
               rx_fifo_we, rx_fifo_din, rx_frame_cnt, rx_drop_cnt);
    end
    sys_rst = 1'b0;
    exp_frames = 0;
    exp_drops  = 0;
    repeat (12) tick();
    cap.delete();
    build_frame(70, 1'b0, 33);
    make_exp(18'h20046, 1000);
    send_frame(-1, -1, 12);
    exp_frames++;
    n_vec++;
    if (cap.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL post reset word count: got %0d want %0d", cap.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
      n_vec++;
      if (cap[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL post reset word %0d: got %h want %h", i, cap[i], exp_q[i]);
      end
    end
    n_vec++;
    if (rx_frame_cnt !== 16'(exp_frames) || rx_drop_cnt !== 16'(exp_drops)) begin
      n_err++;
      $display("FAIL post reset counters: frame=%0d drop=%0d want %0d %0d",
               rx_frame_cnt, rx_drop_cnt, exp_frames, exp_drops);
    end
  endtask

  initial begin
    repeat (3) tick();
    test_reset();
    test_good64();
    test_bad65();
    test_truncate();
    test_held_status();
    test_bad_preamble();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
